// File: rtl/spi_cmd_pkg.sv
// Shared constants, FSM encoding and status-word packing for the SPI command front end.
package spi_cmd_pkg;
   localparam int FRAME_BITS_DEFAULT = 32;

   localparam int ST_TX_VALID  = 31;
   localparam int ST_FRAME_ERR = 30;
   localparam int ST_OVERRUN   = 29;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      CHECK,
      LATCH,
      GUARD
   } frame_state_t;

   // Read-back word returned on MISO: flags on top, echoed address byte, then data.
   function automatic logic [31:0] status_word(input logic        tx_valid,
                                               input logic        frame_error,
                                               input logic        overrun,
                                               input logic [7:0]  addr,
                                               input logic [15:0] data);
      logic [31:0] w;
      w               = {8'h00, addr, data};
      w[ST_TX_VALID]  = tx_valid;
      w[ST_FRAME_ERR] = frame_error;
      w[ST_OVERRUN]   = overrun;
      return w;
   endfunction
endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for an asynchronous SPI pin, with registered one-clock edge pulses.
module spi_pin_sync #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);
   // sr[1:0] is the synchronizer proper; sr[2] is the previous sample for edge detection.
   logic [2:0] sr;

   always_ff @(posedge clock) begin
      if (reset) begin
         sr   <= {3{RESET_VAL}};
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         sr   <= {sr[1:0], pin};
         rise <= sr[1] & ~sr[2];
         fall <= ~sr[1] & sr[2];
      end
   end

   // Level is taken from the edge-detect stage so it lines up with the pulses.
   assign level = sr[2];
endmodule

// File: rtl/spi_command_interface.sv
// SPI slave front end: oversampled mode-0 receive of command frames, strobe to the controller,
// and read-back of controller memory data on MISO during the following frame.
module spi_command_interface
   import spi_cmd_pkg::*;
#(
   parameter int FRAME_BITS   = FRAME_BITS_DEFAULT,
   parameter int LATCH_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        spi_sclk,
   input  logic        spi_cs_n,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        spi_miso_oe,
   output logic [31:0] spi_data,
   output logic        latch_data_sn,
   input  logic [15:0] memory_data,
   input  logic        data_valid_n,
   output logic        frame_error,
   output logic        overrun
);
   logic sclk_level, sclk_rise, sclk_fall;
   logic cs_level, cs_rise, cs_fall;
   logic mosi_level, mosi_rise, mosi_fall;
   logic unused_sync;

   spi_pin_sync #(.RESET_VAL(1'b0)) u_sclk_sync (
      .clock(clock), .reset(reset), .pin(spi_sclk),
      .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
   );

   spi_pin_sync #(.RESET_VAL(1'b1)) u_cs_sync (
      .clock(clock), .reset(reset), .pin(spi_cs_n),
      .level(cs_level), .rise(cs_rise), .fall(cs_fall)
   );

   spi_pin_sync #(.RESET_VAL(1'b0)) u_mosi_sync (
      .clock(clock), .reset(reset), .pin(spi_mosi),
      .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
   );

   assign unused_sync = sclk_level ^ mosi_rise ^ mosi_fall;

   frame_state_t state;
   logic [5:0]   bit_cnt;
   logic [31:0]  rx_shift;
   logic [31:0]  tx_shift;
   logic [15:0]  tx_data;
   logic         tx_valid;
   logic [7:0]   phase_cnt;
   logic [1:0]   warm_cnt;
   logic         armed;
   logic         fall_held;
   logic         frame_ok;

   assign frame_ok    = (state == CHECK) && (bit_cnt == 6'(FRAME_BITS));
   assign spi_miso    = tx_shift[31];
   assign spi_miso_oe = ~cs_level;

   // After reset the CS synchronizer needs 3 clocks to reflect the pin; a frame may only
   // start once CS has been seen inactive, so a frame cut by reset is never picked up midway.
   always_ff @(posedge clock) begin
      if (reset) begin
         warm_cnt <= 2'd0;
         armed    <= 1'b0;
      end else begin
         if (warm_cnt != 2'd3) warm_cnt <= warm_cnt + 2'd1;
         else if (cs_level)    armed    <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         bit_cnt       <= '0;
         rx_shift      <= '0;
         tx_shift      <= '0;
         phase_cnt     <= '0;
         fall_held     <= 1'b0;
         spi_data      <= '0;
         latch_data_sn <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (armed && (cs_fall || fall_held)) begin
                  state     <= SHIFT;
                  bit_cnt   <= '0;
                  fall_held <= 1'b0;
                  tx_shift  <= status_word(tx_valid, frame_error, overrun,
                                           spi_data[23:16], tx_data);
               end
            end
            SHIFT: begin
               if (sclk_rise) begin
                  rx_shift <= {rx_shift[30:0], mosi_level};
                  if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
               end
               if (sclk_fall) tx_shift <= {tx_shift[30:0], 1'b0};
               if (cs_rise)   state    <= CHECK;
            end
            CHECK: begin
               if (frame_ok) begin
                  state         <= LATCH;
                  latch_data_sn <= 1'b0;
                  spi_data      <= rx_shift;
                  phase_cnt     <= 8'(LATCH_CYCLES - 1);
               end else begin
                  state <= IDLE;
               end
            end
            LATCH: begin
               if (phase_cnt == 8'd0) begin
                  state         <= GUARD;
                  latch_data_sn <= 1'b1;
                  phase_cnt     <= 8'd1;
               end else begin
                  phase_cnt <= phase_cnt - 8'd1;
               end
            end
            GUARD: begin
               if (phase_cnt == 8'd0) state     <= IDLE;
               else                   phase_cnt <= phase_cnt - 8'd1;
            end
            default: state <= IDLE;
         endcase

         // A host that starts the next frame early is remembered and served from IDLE.
         if (state == CHECK || state == LATCH || state == GUARD) begin
            if (cs_fall)      fall_held <= 1'b1;
            else if (cs_rise) fall_held <= 1'b0;
         end
      end
   end

   // Read-back capture and read-to-clear status; new data wins over the clear on a tie.
   always_ff @(posedge clock) begin
      if (reset) begin
         tx_data     <= '0;
         tx_valid    <= 1'b0;
         overrun     <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         if (!data_valid_n) begin
            tx_data  <= memory_data;
            tx_valid <= 1'b1;
         end else if (frame_ok) begin
            tx_valid <= 1'b0;
         end

         if (frame_ok)                       overrun <= 1'b0;
         else if (!data_valid_n && tx_valid) overrun <= 1'b1;

         if (frame_ok)             frame_error <= 1'b0;
         else if (state == CHECK)  frame_error <= 1'b1;
      end
   end
endmodule

// File: tb/tb_spi_command_interface.sv
// Scoreboard bench: the host driver pushes expected strobes and MISO words from a
// transaction-level model; independent monitors pop and compare as the DUT responds.
module tb_spi_command_interface;
   localparam int LATCH_CYCLES = 2;
   localparam int HALF         = 5;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        spi_sclk = 1'b0;
   logic        spi_cs_n = 1'b1;
   logic        spi_mosi = 1'b0;
   logic        spi_miso;
   logic        spi_miso_oe;
   logic [31:0] spi_data;
   logic        latch_data_sn;
   logic [15:0] memory_data = 16'h0;
   logic        data_valid_n = 1'b1;
   logic        frame_error;
   logic        overrun;

   spi_command_interface #(.FRAME_BITS(32), .LATCH_CYCLES(LATCH_CYCLES)) dut (
      .clock(clock), .reset(reset),
      .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .spi_data(spi_data), .latch_data_sn(latch_data_sn),
      .memory_data(memory_data), .data_valid_n(data_valid_n),
      .frame_error(frame_error), .overrun(overrun)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int tests = 0;
   int failed = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: host-visible state of the interface, updated per transaction.
   logic [31:0] m_sd;
   logic [15:0] m_td;
   logic        m_tv, m_fe, m_ov;

   function automatic logic [31:0] model_status();
      return {m_tv, m_fe, m_ov, 5'b0, m_sd[23:16], m_td};
   endfunction

   task automatic model_reset();
      m_sd = 32'h0; m_td = 16'h0; m_tv = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
   endtask

   typedef struct { logic [31:0] d; int rc; } strobe_exp_t;
   typedef struct { logic [31:0] w; bit chk; } miso_exp_t;
   strobe_exp_t strobe_q[$];
   miso_exp_t   miso_q[$];

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Strobe monitor: data, CS-rise-to-strobe latency and pulse width.
   logic prev_latch = 1'b1;
   int   low_cnt = 0;
   always @(negedge clock) begin
      if (!reset) begin
         if (!latch_data_sn && prev_latch) begin
            low_cnt = 1;
            if (strobe_q.size() == 0) begin
               check("unexpected_strobe", 64'(spi_data), 64'hx);
            end else begin
               strobe_exp_t e;
               e = strobe_q.pop_front();
               check("spi_data_at_strobe", 64'(spi_data), 64'(e.d));
               check("strobe_latency", 64'(cyc - e.rc), 64'd5);
            end
         end else if (!latch_data_sn) begin
            low_cnt++;
         end else if (!prev_latch) begin
            check("strobe_width", 64'(low_cnt), 64'(LATCH_CYCLES));
         end
      end
      prev_latch = latch_data_sn;
   end

   // MISO monitor: collects the bits the host samples on SCLK rise during one CS window.
   logic [31:0] cap;
   int          cap_n = 0;
   bit          cap_on = 0;
   always @(negedge spi_cs_n) begin
      cap = 32'h0; cap_n = 0; cap_on = 1;
   end
   always @(posedge spi_sclk) begin
      if (cap_on) begin
         if (cap_n < 32) cap = {cap[30:0], spi_miso};
         cap_n++;
      end
   end
   always @(posedge spi_cs_n) begin
      if (cap_on) begin
         cap_on = 0;
         if (miso_q.size() == 0) begin
            check("unexpected_miso_frame", 64'(cap), 64'hx);
         end else begin
            miso_exp_t e;
            e = miso_q.pop_front();
            if (e.chk) begin
               if (cap_n >= 32) check("miso_word", 64'(cap), 64'(e.w));
               else             check("miso_partial", 64'(cap), 64'(e.w >> (32 - cap_n)));
            end
         end
      end
   end

   task automatic post_checks(input string tag);
      check({tag, "_frame_error"}, 64'(frame_error), 64'(m_fe));
      check({tag, "_overrun"}, 64'(overrun), 64'(m_ov));
      check({tag, "_spi_data"}, 64'(spi_data), 64'(m_sd));
      check({tag, "_latch_idle"}, 64'(latch_data_sn), 64'd1);
   endtask

   task automatic readback(input logic [15:0] d);
      data_valid_n = 1'b0; memory_data = d;
      tick(1);
      data_valid_n = 1'b1;
      if (m_tv) m_ov = 1'b1;
      m_tv = 1'b1; m_td = d;
      tick(3);
   endtask

   task automatic send_frame(input logic [69:0] bits, input int n,
                             input bit dv_same, input logic [15:0] dvd);
      int rc;
      miso_q.push_back('{model_status(), 1'b1});
      spi_cs_n = 1'b0;
      tick(6);
      check("miso_oe_active", 64'(spi_miso_oe), 64'd1);
      for (int i = 0; i < n; i++) begin
         spi_mosi = bits[n-1-i];
         tick(HALF); spi_sclk = 1'b1;
         tick(HALF); spi_sclk = 1'b0;
      end
      tick(HALF);
      spi_cs_n = 1'b1;
      rc = cyc;
      if (n == 32) begin
         strobe_q.push_back('{bits[31:0], rc});
         m_sd = bits[31:0]; m_fe = 1'b0; m_ov = 1'b0; m_tv = 1'b0;
      end else begin
         m_fe = 1'b1;
      end
      if (dv_same) begin
         tick(4);
         data_valid_n = 1'b0; memory_data = dvd;
         tick(1);
         data_valid_n = 1'b1;
         m_tv = 1'b1; m_td = dvd;
      end
      tick(20);
   endtask

   task automatic reset_mid_frame(input logic [31:0] bits);
      miso_q.push_back('{32'h0, 1'b0});
      spi_cs_n = 1'b0;
      tick(6);
      for (int i = 0; i < 32; i++) begin
         if (i == 16) begin
            reset = 1'b1; tick(3); reset = 1'b0;
            model_reset();
         end
         spi_mosi = bits[31-i];
         tick(HALF); spi_sclk = 1'b1;
         tick(HALF); spi_sclk = 1'b0;
      end
      tick(HALF);
      spi_cs_n = 1'b1;
      tick(20);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [69:0] rb;
      model_reset();
      reset = 1'b1;
      tick(5);
      check("rst_spi_data", 64'(spi_data), 64'h0);
      check("rst_latch", 64'(latch_data_sn), 64'd1);
      check("rst_miso", 64'(spi_miso), 64'd0);
      check("rst_miso_oe", 64'(spi_miso_oe), 64'd0);
      check("rst_frame_error", 64'(frame_error), 64'd0);
      check("rst_overrun", 64'(overrun), 64'd0);
      reset = 1'b0;
      tick(10);

      send_frame(70'h0312ABCD, 32, 0, 16'h0);
      post_checks("basic");
      send_frame(70'h1234567, 31, 0, 16'h0);
      post_checks("short");
      send_frame(70'h01000000, 32, 0, 16'h0);
      post_checks("after_short");
      readback(16'h5A5A);
      send_frame(70'h02AA0000, 32, 0, 16'h0);
      send_frame(70'h02BB0000, 32, 0, 16'h0);
      readback(16'h1111);
      readback(16'h2222);
      check("overrun_set", 64'(overrun), 64'd1);
      send_frame(70'h03CC0001, 32, 0, 16'h0);
      post_checks("overrun_clear");
      send_frame(70'h04DD0002, 32, 1, 16'h7777);
      post_checks("same_clock");
      send_frame(70'h05EE0003, 32, 0, 16'h0);
      send_frame(70'h0, 66, 0, 16'h0);
      post_checks("saturate");

      reset_mid_frame(32'hDEADBEEF);
      post_checks("reset_mid");
      send_frame(70'h06123456, 32, 0, 16'h0);
      post_checks("after_reset");

      for (int k = 0; k < 30; k++) begin
         int r;
         rb = {6'($urandom), 32'($urandom), 32'($urandom)};
         r  = int'($urandom_range(0, 9));
         if (r <= 4)      send_frame(rb, 32, 0, 16'h0);
         else if (r <= 6) readback(16'($urandom));
         else if (r == 7) send_frame(rb, int'($urandom_range(1, 31)), 0, 16'h0);
         else if (r == 8) send_frame(rb, int'($urandom_range(33, 70)), 0, 16'h0);
         else             send_frame(rb, 32, 1, 16'($urandom));
         post_checks("rand");
      end
      send_frame(70'h0, 32, 0, 16'h0);
      post_checks("final");

      check("strobe_q_drained", 64'(strobe_q.size()), 64'd0);
      check("miso_q_drained", 64'(miso_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
